// File: rtl/bp_me_nonsynth_mem_responder.sv
// Fixed-latency memory endpoint for the CCE memory command channel.
// Holds one command at a time, services it from a flat byte array and returns one response.
package bp_me_nonsynth_mem_responder_pkg;
  localparam int unsigned paddr_width_gp           = 40;
  localparam int unsigned cce_block_width_gp       = 512;
  localparam int unsigned cce_mem_payload_width_gp = 16;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_wb    = 4'd4
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    bp_cce_mem_cmd_type_e                  msg_type;
    logic [paddr_width_gp-1:0]             addr;
    bp_mem_msg_size_e                      size;
    logic [cce_mem_payload_width_gp-1:0]   payload;
    logic [cce_block_width_gp-1:0]         data;
  } bp_cce_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);
endpackage

module bp_me_nonsynth_mem_responder
  import bp_me_nonsynth_mem_responder_pkg::*;
#(
  parameter int unsigned mem_cap_in_bytes_p = 2**16,
  parameter int unsigned latency_p          = 4,
  parameter int unsigned mem_zero_p         = 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i,
  output logic [31:0]                     cmd_count_o,
  output logic                            busy_o
);

  localparam int unsigned blk_bytes_lp  = cce_block_width_gp / 8;
  localparam int unsigned mem_addr_w_lp = $clog2(mem_cap_in_bytes_p);

  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  state_e          state_q, state_d;
  logic [7:0]      lat_cnt_q, lat_cnt_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            resp_v_q, resp_v_d;
  logic            busy_q, busy_d;
  bp_cce_mem_msg_s resp_q, resp_d;

  bp_cce_mem_msg_s                 cmd_c;
  logic                            accept_c;
  logic [mem_addr_w_lp-1:0]        addr_idx_c, blk_idx_c, uc_idx_c;
  logic [3:0]                      uc_bytes_c;
  logic [cce_block_width_gp-1:0]   rd_block_c, resp_data_c;
  logic [63:0]                     uc_rd_c;

  logic [7:0] mem_q [mem_cap_in_bytes_p];

  assign cmd_c      = mem_cmd_i;
  assign accept_c   = mem_cmd_v_i & ready_q;
  assign addr_idx_c = cmd_c.addr[mem_addr_w_lp-1:0];

  // Size-aligned and block-aligned storage indices; wrap is implicit in the truncation.
  always_comb begin
    unique case (cmd_c.size)
      e_mem_size_1: uc_bytes_c = 4'd1;
      e_mem_size_2: uc_bytes_c = 4'd2;
      e_mem_size_4: uc_bytes_c = 4'd4;
      default:      uc_bytes_c = 4'd8;
    endcase
    blk_idx_c = addr_idx_c & ~mem_addr_w_lp'(blk_bytes_lp - 1);
    uc_idx_c  = addr_idx_c & ~mem_addr_w_lp'(32'(uc_bytes_c) - 32'd1);
  end

  always_comb begin
    rd_block_c = '0;
    uc_rd_c    = '0;
    for (int unsigned i = 0; i < blk_bytes_lp; i++)
      rd_block_c[8*i +: 8] = mem_q[blk_idx_c + mem_addr_w_lp'(i)];
    for (int unsigned i = 0; i < 8; i++)
      if (i < 32'(uc_bytes_c)) uc_rd_c[8*i +: 8] = mem_q[uc_idx_c + mem_addr_w_lp'(i)];
  end

  always_comb begin
    resp_data_c = '0;
    unique case (cmd_c.msg_type)
      e_cce_mem_rd, e_cce_mem_wr: resp_data_c = rd_block_c;
      e_cce_mem_uc_rd:            resp_data_c = cce_block_width_gp'(uc_rd_c);
      default:                    resp_data_c = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    unique case (state_q)
      e_ready: if (accept_c) begin
        resp_d      = cmd_c;
        resp_d.data = resp_data_c;
        lat_cnt_d   = 8'(latency_p);
        cnt_d       = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        state_d     = (latency_p == 0) ? e_resp : e_wait;
      end
      e_wait: begin
        lat_cnt_d = lat_cnt_q - 8'd1;
        if (lat_cnt_q == 8'd1) state_d = e_resp;
      end
      e_resp: if (mem_resp_yumi_i) state_d = e_ready;
      default: state_d = e_ready;
    endcase
    ready_d  = (state_d == e_ready);
    resp_v_d = (state_d == e_resp);
    busy_d   = (state_d != e_ready);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= e_ready;
      lat_cnt_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      resp_v_q  <= 1'b0;
      busy_q    <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      resp_v_q  <= resp_v_d;
      busy_q    <= busy_d;
      resp_q    <= resp_d;
    end
  end

  // Writes land at the accept edge, so a later read sees them.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      if (mem_zero_p != 0) mem_q <= '{default: '0};
    end else if (accept_c) begin
      if (cmd_c.msg_type == e_cce_mem_wb) begin
        for (int unsigned i = 0; i < blk_bytes_lp; i++)
          mem_q[blk_idx_c + mem_addr_w_lp'(i)] <= cmd_c.data[8*i +: 8];
      end else if (cmd_c.msg_type == e_cce_mem_uc_wr) begin
        for (int unsigned i = 0; i < 8; i++)
          if (i < 32'(uc_bytes_c)) mem_q[uc_idx_c + mem_addr_w_lp'(i)] <= cmd_c.data[8*i +: 8];
      end
    end
  end

  assign mem_cmd_ready_o = ready_q;
  assign mem_resp_v_o    = resp_v_q;
  assign mem_resp_o      = resp_q;
  assign cmd_count_o     = cnt_q;
  assign busy_o          = busy_q;

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_resp_yumi_i |-> resp_v_q);

endmodule

// File: tb/tb_bp_me_nonsynth_mem_responder.sv
// Bench for bp_me_nonsynth_mem_responder: vector table through a latency-4 instance,
// back-pressure on a latency-0 instance, and reset corner cases.
module tb_bp_me_nonsynth_mem_responder;
  import bp_me_nonsynth_mem_responder_pkg::*;

  localparam int unsigned W   = cce_mem_msg_width_lp;
  localparam int unsigned LAT = 4;

  typedef struct {
    bp_cce_mem_msg_s cmd;
    logic [511:0]    exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] cmd, resp, cmd0, resp0;
  logic cmd_v, ready, resp_v, yumi, busy;
  logic cmd_v0, ready0, resp_v0, yumi0, busy0;
  logic [31:0] cnt, cnt0;

  int checks = 0;
  int failures = 0;
  bp_cce_mem_msg_s exp_q[$];

  bp_me_nonsynth_mem_responder #(.mem_cap_in_bytes_p(2**16), .latency_p(LAT), .mem_zero_p(1)) dut (
    .clk_i(clk), .reset_i(rst), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v), .mem_cmd_ready_o(ready),
    .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_yumi_i(yumi),
    .cmd_count_o(cnt), .busy_o(busy));

  bp_me_nonsynth_mem_responder #(.mem_cap_in_bytes_p(2**16), .latency_p(0), .mem_zero_p(1)) dut0 (
    .clk_i(clk), .reset_i(rst), .mem_cmd_i(cmd0), .mem_cmd_v_i(cmd_v0), .mem_cmd_ready_o(ready0),
    .mem_resp_o(resp0), .mem_resp_v_o(resp_v0), .mem_resp_yumi_i(yumi0),
    .cmd_count_o(cnt0), .busy_o(busy0));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_msg(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                         input bp_mem_msg_size_e s, input logic [511:0] d,
                                         input logic [15:0] p);
    bp_cce_mem_msg_s m;
    m.msg_type = t; m.addr = a; m.size = s; m.payload = p; m.data = d;
    return m;
  endfunction

  function automatic logic [511:0] ramp();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(i);
    return r;
  endfunction

  // Issue one command on the latency-4 instance and score its response.
  task automatic do_txn(input bp_cce_mem_msg_s c, input logic [511:0] exp_data, input string name);
    bp_cce_mem_msg_s e;
    int n, k;
    e = c; e.data = exp_data;
    @(negedge clk);
    cmd = c; cmd_v = 1'b1;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    if (!ready) begin
      chk({name, "_ready_timeout"}, 64'(ready), 64'd1);
      cmd_v = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_v = 1'b0; cmd = '0;
    k = 0;
    while (!resp_v && k < 300) begin @(negedge clk); k++; end
    chk({name, "_latency"}, 64'(k), 64'(LAT));
    e = exp_q.pop_front();
    if (!resp_v) return;
    chk_msg({name, "_resp"}, resp, e);
    @(negedge clk);
    chk_msg({name, "_hold"}, resp, e);
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    chk({name, "_done"}, 64'({resp_v, ready}), 64'b01);
  endtask

  vec_t tbl [12];

  initial begin
    bp_cce_mem_msg_s a, b, e;
    logic [511:0] r2;
    int n;
    logic seen;

    r2 = ramp(); r2[15:0] = 16'hBEEF;
    tbl[0]  = '{mk(e_cce_mem_wb,    40'h1040,  e_mem_size_64, ramp(), 16'hA000), 512'h0};
    tbl[1]  = '{mk(e_cce_mem_rd,    40'h1058,  e_mem_size_64, 512'h0, 16'hA001), ramp()};
    tbl[2]  = '{mk(e_cce_mem_uc_wr, 40'h200,   e_mem_size_8,  512'h1122334455667788, 16'hA002), 512'h0};
    tbl[3]  = '{mk(e_cce_mem_uc_rd, 40'h203,   e_mem_size_2,  512'h0, 16'hA003), 512'h5566};
    tbl[4]  = '{mk(e_cce_mem_uc_wr, 40'h10005, e_mem_size_1,  512'hCDAB, 16'hA004), 512'h0};
    tbl[5]  = '{mk(e_cce_mem_uc_rd, 40'h5,     e_mem_size_1,  512'h0, 16'hA005), 512'hAB};
    tbl[6]  = '{mk(e_cce_mem_uc_rd, 40'h1047,  e_mem_size_4,  512'h0, 16'hA006), 512'h07060504};
    tbl[7]  = '{mk(e_cce_mem_uc_wr, 40'h1041,  e_mem_size_2,  512'hFFFF_BEEF, 16'hA007), 512'h0};
    tbl[8]  = '{mk(e_cce_mem_rd,    40'h107F,  e_mem_size_64, 512'h0, 16'hA008), r2};
    tbl[9]  = '{mk(e_cce_mem_uc_rd, 40'h205,   e_mem_size_8,  512'h0, 16'hA009), 512'h1122334455667788};
    tbl[10] = '{mk(e_cce_mem_wr,    40'h3000,  e_mem_size_64, 512'h0, 16'hA00A), 512'h0};
    tbl[11] = '{mk(e_cce_mem_uc_rd, 40'h7,     e_mem_size_2,  512'h0, 16'hA00B), 512'h0};

    rst = 1'b1;
    cmd = '0; cmd_v = 1'b0; yumi = 1'b0;
    cmd0 = '0; cmd_v0 = 1'b0; yumi0 = 1'b0;

    // Reset and idle
    repeat (5) @(negedge clk);
    chk("reset_outputs", 64'({ready, resp_v, busy}), 64'd0);
    chk("reset_count", 64'(cnt), 64'd0);
    chk_msg("reset_resp", resp, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'({ready, resp_v}), 64'b10);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= resp_v; end
    chk("idle_no_resp", 64'(seen), 64'd0);

    for (int i = 0; i < 12; i++)
      do_txn(tbl[i].cmd, tbl[i].exp_data, $sformatf("vec%0d", i));
    chk("cmd_count_table", 64'(cnt), 64'd12);

    // Back-pressure on the zero-latency instance
    a = mk(e_cce_mem_uc_wr, 40'h10, e_mem_size_1, 512'h5A, 16'h00B1);
    b = mk(e_cce_mem_uc_rd, 40'h10, e_mem_size_1, 512'h0, 16'h00B2);
    @(negedge clk);
    cmd0 = a; cmd_v0 = 1'b1;
    e = a; e.data = '0; exp_q.push_back(e);
    n = 0;
    while (!ready0 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cmd0 = b;
    e = b; e.data = 512'h5A; exp_q.push_back(e);
    n = 0;
    while (!resp_v0 && n < 20) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    chk_msg("bp_first_resp", resp0, e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_ready_low%0d", i), 64'({ready0, resp_v0}), 64'b01);
      chk_msg($sformatf("bp_stable%0d", i), resp0, e);
    end
    chk("bp_count_held", 64'(cnt0), 64'd1);
    yumi0 = 1'b1;
    @(negedge clk);
    yumi0 = 1'b0;
    chk("bp_after_yumi", 64'({ready0, busy0, resp_v0}), 64'b100);
    @(negedge clk);
    cmd_v0 = 1'b0;
    chk("bp_second_accept", 64'({cnt0, busy0}), 64'({32'd2, 1'b1}));
    n = 0;
    while (!resp_v0 && n < 20) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    chk_msg("bp_second_resp", resp0, e);
    yumi0 = 1'b1;
    @(negedge clk);
    yumi0 = 1'b0;

    // Reset while a read is in flight
    @(negedge clk);
    cmd = mk(e_cce_mem_rd, 40'h1040, e_mem_size_64, 512'h0, 16'hC000); cmd_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_v = 1'b0;
    chk("mid_accepted", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_async_reset", 64'({ready, resp_v, busy}), 64'd0);
    chk("mid_count_cleared", 64'(cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= resp_v; end
    chk("mid_no_resp", 64'(seen), 64'd0);
    do_txn(mk(e_cce_mem_uc_rd, 40'h5, e_mem_size_1, 512'h0, 16'hC001), 512'h0, "post_reset");
    chk("post_reset_count", 64'(cnt), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
